// File: rtl/temp_alarm_ctrl.sv
// Temperature alarm sequencer: threshold compare with hysteresis, debounced
// acknowledge button and a timed mute window, producing the buzzer sel code.
module temp_alarm_ctrl #(
  parameter int unsigned WARN_TH      = 50,
  parameter int unsigned CRIT_TH      = 70,
  parameter int unsigned HYST         = 2,
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned MUTE_CYC     = 1500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] temp,
  input  logic       temp_valid,
  input  logic       ack_n,
  output logic [1:0] sel,
  output logic       alarm_active,
  output logic       muted
);

  typedef enum logic [1:0] {StNormal, StWarn, StCrit, StMuted} state_e;

  // Thresholds in half-degree units so the +0.5 flag lands in the LSB.
  localparam logic [6:0]  WarnDeg     = 7'(WARN_TH);
  localparam logic [6:0]  CritDeg     = 7'(CRIT_TH);
  localparam logic [6:0]  WarnHystDeg = 7'(WARN_TH - HYST);
  localparam logic [6:0]  CritHystDeg = 7'(CRIT_TH - HYST);
  localparam logic [7:0]  WarnHalf    = {WarnDeg, 1'b0};
  localparam logic [7:0]  CritHalf    = {CritDeg, 1'b0};
  localparam logic [7:0]  WarnHystHalf = {WarnHystDeg, 1'b0};
  localparam logic [7:0]  CritHystHalf = {CritHystDeg, 1'b0};
  localparam logic [31:0] DebLast     = 32'(DEBOUNCE_CYC - 1);
  localparam logic [31:0] MuteLast    = 32'(MUTE_CYC - 1);

  logic        ack_s1, ack_s2;
  logic        deb_level, deb_level_prev;
  logic [31:0] deb_cnt;
  logic        press;

  logic [7:0]  tval;
  logic        ge_crit, ge_warn, lt_warn_hyst, lt_crit_hyst;

  state_e      state_q, state_d;
  logic [31:0] mute_cnt_q, mute_cnt_d;
  logic [1:0]  sel_d;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_s1 <= 1'b1;
      ack_s2 <= 1'b1;
    end else begin
      ack_s1 <= ack_n;
      ack_s2 <= ack_s1;
    end
  end

  // Debounce: accept a new level only after it has been held long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_level      <= 1'b1;
      deb_level_prev <= 1'b1;
      deb_cnt        <= '0;
    end else begin
      deb_level_prev <= deb_level;
      if (ack_s2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DebLast) begin
        deb_level <= ~deb_level;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 32'd1;
      end
    end
  end

  // Press is the falling edge of the debounced level; release is ignored.
  assign press = deb_level_prev & ~deb_level;

  assign tval         = {temp[6:0], temp[7]};
  assign ge_crit      = tval >= CritHalf;
  assign ge_warn      = tval >= WarnHalf;
  assign lt_warn_hyst = tval < WarnHystHalf;
  assign lt_crit_hyst = tval < CritHystHalf;

  // Next-state logic; temperature exits take priority over press and timeout.
  always_comb begin
    state_d    = state_q;
    mute_cnt_d = mute_cnt_q;
    unique case (state_q)
      StNormal: begin
        if (temp_valid) begin
          if (ge_crit)      state_d = StCrit;
          else if (ge_warn) state_d = StWarn;
        end
      end
      StWarn: begin
        if (temp_valid) begin
          if (ge_crit)           state_d = StCrit;
          else if (lt_warn_hyst) state_d = StNormal;
        end
      end
      StCrit: begin
        if (temp_valid && lt_warn_hyst) begin
          state_d = StNormal;
        end else if (temp_valid && lt_crit_hyst) begin
          state_d = StWarn;
        end else if (press) begin
          state_d    = StMuted;
          mute_cnt_d = '0;
        end
      end
      StMuted: begin
        if (temp_valid && lt_warn_hyst) begin
          state_d    = StNormal;
          mute_cnt_d = '0;
        end else if (temp_valid && lt_crit_hyst) begin
          state_d    = StWarn;
          mute_cnt_d = '0;
        end else if (mute_cnt_q == MuteLast) begin
          state_d    = StCrit;
          mute_cnt_d = '0;
        end else begin
          mute_cnt_d = mute_cnt_q + 32'd1;
        end
      end
      default: begin
        state_d    = StNormal;
        mute_cnt_d = '0;
      end
    endcase
  end

  // Buzzer code for the upcoming state.
  always_comb begin
    sel_d = 2'b00;
    unique case (state_d)
      StNormal: sel_d = 2'b00;
      StWarn:   sel_d = 2'b01;
      StCrit:   sel_d = 2'b11;
      StMuted:  sel_d = 2'b10;
      default:  sel_d = 2'b00;
    endcase
  end

  // State, mute counter and registered outputs move on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StNormal;
      mute_cnt_q   <= '0;
      sel          <= 2'b00;
      alarm_active <= 1'b0;
      muted        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mute_cnt_q   <= mute_cnt_d;
      sel          <= sel_d;
      alarm_active <= (state_d == StCrit) || (state_d == StMuted);
      muted        <= (state_d == StMuted);
    end
  end

endmodule

// File: tb/tb_temp_alarm_ctrl.sv
// Bench for temp_alarm_ctrl: directed scenarios, a cycle-level reference
// model checked on every falling edge, plus literal expectations.
module tb_temp_alarm_ctrl;

  localparam int unsigned W   = 50;
  localparam int unsigned C   = 70;
  localparam int unsigned H   = 2;
  localparam int unsigned DEB = 4;
  localparam int unsigned MUT = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] temp = 8'h00;
  logic       temp_valid = 1'b0;
  logic       ack_n = 1'b1;
  logic [1:0] sel;
  logic       alarm_active;
  logic       muted;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;
  bit muted_seen = 1'b0;

  temp_alarm_ctrl #(
    .WARN_TH(W), .CRIT_TH(C), .HYST(H), .DEBOUNCE_CYC(DEB), .MUTE_CYC(MUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .temp(temp), .temp_valid(temp_valid), .ack_n(ack_n),
    .sel(sel), .alarm_active(alarm_active), .muted(muted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: mode 0 normal, 1 warn, 2 critical, 3 muted.
  int m_mode = 0;
  int m_cyc = 0;
  int m_mute_start = 0;
  int m_run = 0;
  bit m_hist0 = 1'b1, m_hist1 = 1'b1;
  bit m_level = 1'b1;
  bit m_pend = 1'b0;

  function automatic int mode_sel(input int m);
    case (m)
      1: return 1;
      2: return 3;
      3: return 2;
      default: return 0;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_cyc = 0; m_mute_start = 0; m_run = 0;
      m_hist0 = 1'b1; m_hist1 = 1'b1; m_level = 1'b1; m_pend = 1'b0;
    end else begin
      int t;
      bit press_now, synced;
      bit ge_c, ge_w, lt_wh, lt_ch;
      m_cyc++;
      // A press becomes visible the cycle after the debounced level falls.
      press_now = m_pend;
      m_pend = 1'b0;
      synced = m_hist1;
      if (synced != m_level) begin
        m_run++;
        if (m_run == DEB) begin
          m_level = synced;
          m_run = 0;
          if (!m_level) m_pend = 1'b1;
        end
      end else begin
        m_run = 0;
      end
      m_hist1 = m_hist0;
      m_hist0 = ack_n;

      t = int'(temp[6:0]) * 2 + int'(temp[7]);
      ge_c  = temp_valid && (t >= 2 * C);
      ge_w  = temp_valid && (t >= 2 * W);
      lt_wh = temp_valid && (t < 2 * (W - H));
      lt_ch = temp_valid && (t < 2 * (C - H));
      case (m_mode)
        0: if (ge_c) m_mode = 2; else if (ge_w) m_mode = 1;
        1: if (ge_c) m_mode = 2; else if (lt_wh) m_mode = 0;
        2: begin
          if (lt_wh) m_mode = 0;
          else if (lt_ch) m_mode = 1;
          else if (press_now) begin m_mode = 3; m_mute_start = m_cyc; end
        end
        default: begin
          if (lt_wh) m_mode = 0;
          else if (lt_ch) m_mode = 1;
          else if (m_cyc - m_mute_start == MUT) m_mode = 2;
        end
      endcase
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n && chk_on) begin
      check("model_sel", int'(sel), mode_sel(m_mode));
      check("model_alarm", int'(alarm_active), int'(m_mode >= 2));
      check("model_muted", int'(muted), int'(m_mode == 3));
    end
    if (muted) muted_seen = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic send(input logic [7:0] t);
    @(negedge clk);
    temp = t;
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
  endtask

  task automatic hold_ack(input int cycles);
    @(negedge clk);
    ack_n = 1'b0;
    repeat (cycles) @(negedge clk);
    ack_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_sel", int'(sel), 0);
    check("reset_alarm", int'(alarm_active), 0);
    check("reset_muted", int'(muted), 0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);

    // 1: warning entry and hysteresis exit
    send(8'h32); check("t1_warn", int'(sel), 1);
    send(8'h30); check("t1_hyst_hold", int'(sel), 1);
    send(8'h2F); check("t1_normal", int'(sel), 0);

    // 2: critical entry, half-degree hysteresis hold, drop to warn
    send(8'h46); check("t2_crit", int'(sel), 3); check("t2_alarm", int'(alarm_active), 1);
    send(8'hC4); check("t2_hold", int'(sel), 3);
    send(8'h43); check("t2_warn", int'(sel), 1);

    // 3: short press rejected, long press mutes, timeout re-arms
    send(8'h46);
    hold_ack(3);
    repeat (8) @(negedge clk);
    check("t3_short", int'(sel), 3);
    hold_ack(8);
    check("t3_mute_sel", int'(sel), 2);
    check("t3_muted", int'(muted), 1);
    repeat (40) @(negedge clk);
    check("t3_still_muted", int'(muted), 1);
    repeat (62) @(negedge clk);
    check("t3_rearm_sel", int'(sel), 3);
    check("t3_rearm_muted", int'(muted), 0);

    // 4: glitchy button never debounces
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ack_n = ((i / 2) % 2) != 0;
    end
    ack_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t4_glitch", int'(sel), 3);

    // 5a: temperature exit on the press cycle wins
    muted_seen = 1'b0;
    @(negedge clk);
    ack_n = 1'b0;
    repeat (6) @(negedge clk);
    temp = 8'h2A;
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
    check("t5_exit_sel", int'(sel), 0);
    repeat (4) @(negedge clk);
    ack_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_never_muted", int'(muted_seen), 0);

    // 5b: from muted, a warm sample drops to warn
    send(8'h46);
    hold_ack(8);
    check("t5_muted", int'(sel), 2);
    repeat (10) @(negedge clk);
    send(8'h3C);
    check("t5_warn", int'(sel), 1);
    check("t5_unmuted", int'(muted), 0);

    // 6: asynchronous reset in the middle of a mute window
    send(8'h46);
    hold_ack(8);
    check("t6_muted", int'(muted), 1);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_sel", int'(sel), 0);
    check("t6_rst_muted", int'(muted), 0);
    check("t6_rst_alarm", int'(alarm_active), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'h46);
    check("t6_crit", int'(sel), 3);
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
